// File: rtl/conway_sweep_controller.sv
// Raster-order sweep sequencer for the banked Conway generation datapath.
// Issues 9 neighbourhood reads per pixel, then the centre write one cycle later.
module conway_sweep_controller #(
  parameter int ADDR_WIDTH    = 2,
  parameter int HEIGHT_PIXELS = 6,
  parameter int WIDTH_PIXELS  = 6,
  parameter int HEIGHT_BLOCKS = 2,
  parameter int WIDTH_BLOCKS  = 2,
  parameter int GEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [GEN_WIDTH-1:0]  generation,
  output logic [8:0]            read_enable,
  output logic [ADDR_WIDTH-1:0] read_addr_0,
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [ADDR_WIDTH-1:0] read_addr_3,
  output logic [ADDR_WIDTH-1:0] read_addr_4,
  output logic [ADDR_WIDTH-1:0] read_addr_5,
  output logic [ADDR_WIDTH-1:0] read_addr_6,
  output logic [ADDR_WIDTH-1:0] read_addr_7,
  output logic [ADDR_WIDTH-1:0] read_addr_8,
  output logic [8:0]            write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  frame_buffer_select
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] XB_LAST = AW'(WIDTH_BLOCKS - 1);
  localparam logic [AW-1:0] YB_LAST = AW'(HEIGHT_BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q;
  logic [1:0]            xs_q, ys_q;
  logic [AW-1:0]         xb_q, yb_q;
  logic                  last_q;
  logic [3:0]            cbank_q;
  logic [AW-1:0]         caddr_q;
  logic                  busy_q, done_q, fbs_q;
  logic [GEN_WIDTH-1:0]  gen_q;
  logic [8:0]            re_q, we_q;
  logic [AW-1:0]         wa_q;
  logic [AW-1:0]         ra_q [9];

  logic [1:0]            nxs [3], nys [3];
  logic [AW-1:0]         nxb [3], nyb [3];
  logic [AW-1:0]         ra_d [9];
  logic [3:0]            cbank_d;
  logic [AW-1:0]         caddr_d;
  logic                  last_d, issue;

  // index 0/1/2 = offset -1/0/+1, wrapping sub then block toroidally
  always_comb begin
    nxs[1] = xs_q;
    nxb[1] = xb_q;
    nys[1] = ys_q;
    nyb[1] = yb_q;
    nxs[0] = (xs_q == 2'd0) ? 2'd2 : xs_q - 2'd1;
    nxs[2] = (xs_q == 2'd2) ? 2'd0 : xs_q + 2'd1;
    nys[0] = (ys_q == 2'd0) ? 2'd2 : ys_q - 2'd1;
    nys[2] = (ys_q == 2'd2) ? 2'd0 : ys_q + 2'd1;
    nxb[0] = xb_q;
    nxb[2] = xb_q;
    nyb[0] = yb_q;
    nyb[2] = yb_q;
    if (xs_q == 2'd0)
      nxb[0] = (xb_q == '0) ? XB_LAST : xb_q - 1'b1;
    if (xs_q == 2'd2)
      nxb[2] = (xb_q == XB_LAST) ? '0 : xb_q + 1'b1;
    if (ys_q == 2'd0)
      nyb[0] = (yb_q == '0) ? YB_LAST : yb_q - 1'b1;
    if (ys_q == 2'd2)
      nyb[2] = (yb_q == YB_LAST) ? '0 : yb_q + 1'b1;
  end

  always_comb begin
    logic [3:0] bk;
    bk = '0;
    for (int k = 0; k < 9; k++) ra_d[k] = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        bk = 4'(nys[i] * 3 + nxs[j]);
        ra_d[bk] = AW'(nyb[i] * WIDTH_BLOCKS + nxb[j]);
      end
    end
    cbank_d = 4'(ys_q * 3 + xs_q);
    caddr_d = AW'(yb_q * WIDTH_BLOCKS + xb_q);
    last_d  = (xs_q == 2'd2) && (ys_q == 2'd2) &&
              (xb_q == XB_LAST) && (yb_q == YB_LAST);
    issue   = ((state_q == IDLE) && start) ||
              ((state_q == RUN) && !last_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      xb_q    <= '0;
      yb_q    <= '0;
      last_q  <= 1'b0;
      cbank_q <= '0;
      caddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fbs_q   <= 1'b0;
      gen_q   <= '0;
      re_q    <= '0;
      we_q    <= '0;
      wa_q    <= '0;
      for (int k = 0; k < 9; k++) ra_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      re_q   <= '0;
      we_q   <= '0;
      wa_q   <= '0;
      for (int k = 0; k < 9; k++) ra_q[k] <= '0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          we_q <= 9'd1 << cbank_q;
          wa_q <= caddr_q;
          if (last_q) state_q <= DRAIN;
        end
        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          fbs_q   <= ~fbs_q;
          gen_q   <= gen_q + 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      if (issue) begin
        re_q    <= 9'h1FF;
        ra_q    <= ra_d;
        cbank_q <= cbank_d;
        caddr_q <= caddr_d;
        last_q  <= last_d;
        // raster advance; the last pixel wraps everything back to (0,0)
        if (xs_q != 2'd2) begin
          xs_q <= xs_q + 2'd1;
        end else begin
          xs_q <= 2'd0;
          if (xb_q != XB_LAST) begin
            xb_q <= xb_q + 1'b1;
          end else begin
            xb_q <= '0;
            if (ys_q != 2'd2) begin
              ys_q <= ys_q + 2'd1;
            end else begin
              ys_q <= 2'd0;
              yb_q <= (yb_q == YB_LAST) ? '0 : yb_q + 1'b1;
            end
          end
        end
      end
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign generation          = gen_q;
  assign read_enable         = re_q;
  assign read_addr_0         = ra_q[0];
  assign read_addr_1         = ra_q[1];
  assign read_addr_2         = ra_q[2];
  assign read_addr_3         = ra_q[3];
  assign read_addr_4         = ra_q[4];
  assign read_addr_5         = ra_q[5];
  assign read_addr_6         = ra_q[6];
  assign read_addr_7         = ra_q[7];
  assign read_addr_8         = ra_q[8];
  assign write_enable        = we_q;
  assign write_addr          = wa_q;
  assign frame_buffer_select = fbs_q;

endmodule

// File: tb/tb_conway_sweep_controller.sv
// Bench for conway_sweep_controller: per-cycle expected outputs are queued
// from a coordinate-level reference model and compared every cycle.
module tb_conway_sweep_controller;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int WB = 2;
  localparam int N  = W * H;
  localparam int GW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, fbs;
  logic [GW-1:0] generation;
  logic [8:0]    read_enable, write_enable;
  logic [1:0]    ra0, ra1, ra2, ra3, ra4, ra5, ra6, ra7, ra8, write_addr;

  conway_sweep_controller #(
    .ADDR_WIDTH(2), .HEIGHT_PIXELS(H), .WIDTH_PIXELS(W),
    .HEIGHT_BLOCKS(2), .WIDTH_BLOCKS(WB), .GEN_WIDTH(GW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .generation(generation),
    .read_enable(read_enable),
    .read_addr_0(ra0), .read_addr_1(ra1), .read_addr_2(ra2),
    .read_addr_3(ra3), .read_addr_4(ra4), .read_addr_5(ra5),
    .read_addr_6(ra6), .read_addr_7(ra7), .read_addr_8(ra8),
    .write_enable(write_enable), .write_addr(write_addr),
    .frame_buffer_select(fbs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          busy;
    logic          done;
    logic [8:0]    re;
    logic [17:0]   ra;
    logic [8:0]    we;
    logic [1:0]    wa;
    logic          fbs;
    logic [GW-1:0] gen;
  } exp_t;

  exp_t          q[$];
  int            ncmp = 0;
  int            nfail = 0;
  int            cyc = 0;
  logic          cur_busy = 1'b0;
  logic          mf = 1'b0;
  logic [GW-1:0] mg = '0;

  function automatic int bank_of(int x, int y);
    return (y % 3) * 3 + (x % 3);
  endfunction

  function automatic int addr_of(int x, int y);
    return (y / 3) * WB + (x / 3);
  endfunction

  function automatic exp_t idle_rec();
    exp_t r;
    r.busy = 0; r.done = 0; r.re = 0; r.ra = 0;
    r.we = 0; r.wa = 0; r.fbs = mf; r.gen = mg;
    return r;
  endfunction

  task automatic push_gen();
    exp_t r;
    for (int c = 1; c <= N + 2; c++) begin
      r = idle_rec();
      r.busy = 1'b1;
      if (c <= N) begin
        int x, y;
        int used;
        x = (c - 1) % W;
        y = (c - 1) / W;
        used = 0;
        r.re = 9'h1FF;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny, b;
            nx = (x + dx + W) % W;
            ny = (y + dy + H) % H;
            b = bank_of(nx, ny);
            used |= (1 << b);
            r.ra[b*2 +: 2] = 2'(addr_of(nx, ny));
          end
        if (used != 32'h1FF) $fatal(1, "model bank coverage broken");
      end
      if (c >= 2 && c <= N + 1) begin
        int x, y;
        x = (c - 2) % W;
        y = (c - 2) / W;
        r.we = 9'(1 << bank_of(x, y));
        r.wa = 2'(addr_of(x, y));
      end
      if (c == N + 2) begin
        r.done = 1'b1;
        r.fbs = ~mf;
        r.gen = mg + 1'b1;
      end
      q.push_back(r);
    end
    mf = ~mf;
    mg = mg + 1'b1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(logic st, logic rst);
    exp_t e;
    start = st;
    reset = rst;
    if (rst) begin
      q.delete();
      mf = 1'b0;
      mg = '0;
      q.push_back(idle_rec());
    end else if (!cur_busy && st && q.size() == 0) begin
      push_gen();
    end else if (q.size() == 0) begin
      q.push_back(idle_rec());
    end
    @(posedge clk);
    #1;
    cyc++;
    e = q.pop_front();
    cur_busy = e.busy;
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    chk("read_enable", 32'(read_enable), 32'(e.re));
    chk("read_addr", 32'({ra8, ra7, ra6, ra5, ra4, ra3, ra2, ra1, ra0}),
        32'(e.ra));
    chk("write_enable", 32'(write_enable), 32'(e.we));
    chk("write_addr", 32'(write_addr), 32'(e.wa));
    chk("fb_select", 32'(fbs), 32'(e.fbs));
    chk("generation", 32'(generation), 32'(e.gen));
  endtask

  initial begin
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    // single generation from a start pulse
    tick(1'b1, 1'b0);
    repeat (40) tick(1'b0, 1'b0);
    // start held high: back-to-back generations, generation counter wraps
    repeat (3 * 39) tick(1'b1, 1'b0);
    repeat (41) tick(1'b0, 1'b0);
    // reset in the middle of a sweep, then a clean restart
    tick(1'b1, 1'b0);
    repeat (19) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (40) tick(1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
